serial_slice_adder: RTL and testbench

- Parametrised multi-cycle two's-complement adder/subtractor; successor to the 4-bit combinational full adder.
- Processes SLICE bits per clock, LSB slice first, with a ripple carry held in a register between cycles.
- Valid/ready handshake on input and output; reports sum, carryout and signed overflow.
- Sits between the operand register file and the ALU result mux wherever a narrow, low-area adder is sufficient.

---
 rtl/serial_slice_adder.sv | 197 +++++++++++++++++++
 tb/tb_serial_slice_adder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_slice_adder.sv
// serial_slice_adder
// Multi-cycle two's-complement adder/subtractor. Operands are latched on
// acceptance and consumed SLICE bits per clock, LSB slice first, with the
// ripple carry kept in a register between cycles. The latched operand
// registers shift right by one slice per RUN cycle, so the adder always
// reads their bottom slice. The sum register shifts in from the top, which
// leaves the full result in place after the last slice.
module serial_slice_adder #(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             subtract,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carryout,
   output logic             overflow,
   output logic             busy
);

   localparam int K  = (SLICE > 0) ? (WIDTH / SLICE) : 1;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   // Elaboration-time parameter legality.
   if (WIDTH < 2) begin : g_bad_width
      $error("serial_slice_adder: WIDTH must be at least 2");
   end
   if (SLICE < 1) begin : g_bad_slice
      $error("serial_slice_adder: SLICE must be at least 1");
   end else if ((WIDTH % SLICE) != 0) begin : g_bad_ratio
      $error("serial_slice_adder: WIDTH must be a multiple of SLICE");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nx_s;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic [WIDTH-1:0]  sum_r;
   logic [WIDTH-1:0]  sum_nx_s;
   logic              carry_r;
   logic              carryout_r;
   logic              overflow_r;
   logic              out_valid_r;
   logic              busy_r;
   logic              in_ready_r;
   logic [CW-1:0]     cnt_r;
   logic              last_s;
   logic [SLICE-1:0]  slice_sum_s;
   logic              slice_co_s;
   logic              slice_ov_s;

   // One slice of ripple addition: {carry_out, sum}.
   function automatic logic [SLICE:0] slice_add(
      input logic [SLICE-1:0] x,
      input logic [SLICE-1:0] y,
      input logic             cin
   );
      slice_add = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, cin};
   endfunction

   // Signed overflow from the operand sign bits and the result sign bit.
   function automatic logic signed_ovf(
      input logic sign_a,
      input logic sign_b,
      input logic sign_s
   );
      signed_ovf = (sign_a == sign_b) && (sign_s != sign_a);
   endfunction

   assign {slice_co_s, slice_sum_s} = slice_add(a_r[SLICE-1:0], b_r[SLICE-1:0], carry_r);

   // On the last slice the shifted operand registers hold the original MSBs
   // at bit SLICE-1, and the new slice sum carries the result MSB.
   assign slice_ov_s = signed_ovf(a_r[SLICE-1], b_r[SLICE-1], slice_sum_s[SLICE-1]);

   assign last_s = (cnt_r == CW'(K - 1));

   if (SLICE < WIDTH) begin : g_multi
      assign sum_nx_s = {slice_sum_s, sum_r[WIDTH-1:SLICE]};
   end else begin : g_single
      assign sum_nx_s = slice_sum_s;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode: accept in IDLE, step through K slices, wait for consumer.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_nx_s = RUN;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Datapath: latch operands on acceptance, add one slice per RUN cycle, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r        <= {WIDTH{1'b0}};
         b_r        <= {WIDTH{1'b0}};
         sum_r      <= {WIDTH{1'b0}};
         carry_r    <= 1'b0;
         carryout_r <= 1'b0;
         overflow_r <= 1'b0;
         cnt_r      <= {CW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_r     <= a;
                  b_r     <= subtract ? ~b : b;
                  carry_r <= subtract;
                  cnt_r   <= {CW{1'b0}};
               end
            end
            RUN: begin
               a_r     <= a_r >> SLICE;
               b_r     <= b_r >> SLICE;
               sum_r   <= sum_nx_s;
               carry_r <= slice_co_s;
               cnt_r   <= cnt_r + CW'(1);
               if (last_s) begin
                  carryout_r <= slice_co_s;
                  overflow_r <= slice_ov_s;
               end
            end
            DONE: begin
               // results held until the next acceptance
            end
            default: begin
               cnt_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   // Handshake and status flags, registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         out_valid_r <= (state_nx_s == DONE);
         busy_r      <= (state_nx_s != IDLE);
         in_ready_r  <= (state_nx_s == IDLE);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign sum       = sum_r;
   assign carryout  = carryout_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_serial_slice_adder.sv
// Bench for serial_slice_adder: a default 32/4 instance and a 4/2 instance,
// with a scoreboard queue of expected results filled at stimulus time.
module tb_serial_slice_adder;

   typedef struct packed {
      logic [31:0] s;
      logic        co;
      logic        ov;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid_w, in_ready_w, sub_w, out_valid_w, out_ready_w, co_w, ov_w, busy_w;
   logic [31:0] a_w, b_w, sum_w;
   logic        in_valid_n, in_ready_n, sub_n, out_valid_n, out_ready_n, co_n, ov_n, busy_n;
   logic [3:0]  a_n, b_n, sum_n;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   serial_slice_adder u_dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
      .a(a_w), .b(b_w), .subtract(sub_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
      .sum(sum_w), .carryout(co_w), .overflow(ov_w), .busy(busy_w)
   );

   serial_slice_adder #(.WIDTH(4), .SLICE(2)) u_dut_n (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_n), .in_ready(in_ready_n),
      .a(a_n), .b(b_n), .subtract(sub_n), .out_valid(out_valid_n), .out_ready(out_ready_n),
      .sum(sum_n), .carryout(co_n), .overflow(ov_n), .busy(busy_n)
   );

   // Reference: whole-word arithmetic, overflow from operand/result signs.
   function automatic exp_t model(input bit nar, input logic [31:0] av, input logic [31:0] bv, input logic sv);
      int          w;
      logic [32:0] m;
      logic [32:0] full;
      logic [31:0] bb;
      logic [31:0] s;
      exp_t        e;
      w    = nar ? 4 : 32;
      m    = (33'd1 << w) - 33'd1;
      bb   = sv ? ~bv : bv;
      full = ({1'b0, av} & m) + ({1'b0, bb} & m) + {32'd0, sv};
      s    = full[31:0] & m[31:0];
      e.s  = s;
      e.co = full[w];
      if (sv) e.ov = (av[w-1] != bv[w-1]) && (s[w-1] != av[w-1]);
      else    e.ov = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
      return e;
   endfunction

   function automatic exp_t obs(input bit nar);
      exp_t e;
      e.s  = nar ? {28'd0, sum_n} : sum_w;
      e.co = nar ? co_n : co_w;
      e.ov = nar ? ov_n : ov_w;
      return e;
   endfunction

   function automatic logic o_valid(input bit nar);
      return nar ? out_valid_n : out_valid_w;
   endfunction

   function automatic logic o_ready(input bit nar);
      return nar ? in_ready_n : in_ready_w;
   endfunction

   function automatic logic o_busy(input bit nar);
      return nar ? busy_n : busy_w;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit nar, input logic [31:0] av, input logic [31:0] bv, input logic sv, input logic v);
      if (nar) begin
         a_n = av[3:0]; b_n = bv[3:0]; sub_n = sv; in_valid_n = v;
      end else begin
         a_w = av; b_w = bv; sub_w = sv; in_valid_w = v;
      end
   endtask

   task automatic set_ordy(input bit nar, input logic v);
      if (nar) out_ready_n = v;
      else     out_ready_w = v;
   endtask

   // Push expectation, present operands for one edge (the acceptance edge).
   task automatic start_txn(input bit nar, input logic [31:0] av, input logic [31:0] bv, input logic sv);
      sb.push_back(model(nar, av, bv, sv));
      drive(nar, av, bv, sv, 1'b1);
      tick;
      drive(nar, av, bv, sv, 1'b0);
   endtask

   // Count edges after acceptance until out_valid; optionally scramble inputs meanwhile.
   task automatic wait_valid(input bit nar, input bit corrupt, output int n, output bit seen);
      logic [31:0] r;
      n = 0;
      seen = 1'b0;
      while (n < 40 && !seen) begin
         if (corrupt) begin
            r = $urandom();
            drive(nar, $urandom(), $urandom(), r[0], 1'b0);
         end
         tick;
         n++;
         seen = o_valid(nar);
      end
   endtask

   task automatic finish_txn(input bit nar);
      set_ordy(nar, 1'b1);
      tick;
      set_ordy(nar, 1'b0);
   endtask

   task automatic test_reset;
      logic [37:0] got;
      rst_n = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      drive(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
      out_ready_w = 1'b0;
      out_ready_n = 1'b0;
      repeat (2) tick;
      for (int i = 0; i < 2; i++) begin
         got = {obs(i[0]), o_valid(i[0]), o_busy(i[0]), o_ready(i[0])};
         total++;
         if (got !== {32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state dut%0d got=%h want=%h", i, got, {32'd0, 5'b00001});
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick;
   endtask

   // Plain add/sub transactions with latency and result checks.
   task automatic test_basic(input bit nar, input logic [31:0] av, input logic [31:0] bv, input logic sv,
                             input int exp_lat, input bit corrupt, input string nm);
      int   n;
      bit   seen;
      exp_t e;
      exp_t o;
      total++;
      if (o_ready(nar) !== 1'b1) begin
         bad++;
         $display("FAIL %s_ready_idle got=%b want=1", nm, o_ready(nar));
      end
      start_txn(nar, av, bv, sv);
      wait_valid(nar, corrupt, n, seen);
      total++;
      if (!seen || n != exp_lat) begin
         bad++;
         $display("FAIL %s_latency got=%0d (seen=%0d) want=%0d", nm, n, seen, exp_lat);
      end
      e = sb.pop_front();
      o = obs(nar);
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL %s_result got=%h/%b/%b want=%h/%b/%b", nm, o.s, o.co, o.ov, e.s, e.co, e.ov);
      end
      finish_txn(nar);
      total++;
      if ({o_valid(nar), o_ready(nar), o_busy(nar)} !== 3'b010) begin
         bad++;
         $display("FAIL %s_release got=%b want=010", nm, {o_valid(nar), o_ready(nar), o_busy(nar)});
      end
   endtask

   task automatic test_w4;
      test_basic(1'b1, 32'h4, 32'h4, 1'b0, 2, 1'b0, "w4_0100p0100");
      test_basic(1'b1, 32'h8, 32'h8, 1'b0, 2, 1'b0, "w4_1000p1000");
      test_basic(1'b1, 32'hF, 32'hF, 1'b0, 2, 1'b0, "w4_1111p1111");
      test_basic(1'b1, 32'h3, 32'h5, 1'b1, 2, 1'b0, "w4_sub");
   endtask

   task automatic test_sub32;
      test_basic(1'b0, 32'h8000_0000, 32'h1, 1'b1, 8, 1'b0, "w32_minint_m1");
      test_basic(1'b0, 32'd5, 32'd7, 1'b1, 8, 1'b0, "w32_5m7");
      test_basic(1'b0, 32'h1234_5678, 32'h1234_5678, 1'b1, 8, 1'b0, "w32_self_sub");
   endtask

   task automatic test_random;
      logic [31:0] r;
      for (int i = 0; i < 6; i++) begin
         r = $urandom();
         test_basic(i[0], $urandom(), $urandom(), r[0], i[0] ? 2 : 8, 1'b0, "rand");
      end
   endtask

   task automatic test_corruption;
      test_basic(1'b0, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 8, 1'b1, "corrupt_add");
      test_basic(1'b0, 32'h0000_0010, 32'h7FFF_0000, 1'b1, 8, 1'b1, "corrupt_sub");
      test_basic(1'b1, 32'h7, 32'h2, 1'b0, 2, 1'b1, "corrupt_w4");
   endtask

   task automatic test_backpressure;
      int   n;
      bit   seen;
      exp_t e;
      exp_t o;
      start_txn(1'b0, 32'h7000_0001, 32'h1000_0002, 1'b0);
      wait_valid(1'b0, 1'b0, n, seen);
      e = sb.pop_front();
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL bp_no_valid got=0 want=1");
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, $urandom(), $urandom(), 1'b1, 1'b1);
         tick;
         o = obs(1'b0);
         total++;
         if ({out_valid_w, in_ready_w} !== 2'b10 || o !== e) begin
            bad++;
            $display("FAIL bp_hold%0d got=%b%b %h/%b/%b want=10 %h/%b/%b",
                     i, out_valid_w, in_ready_w, o.s, o.co, o.ov, e.s, e.co, e.ov);
         end
      end
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      finish_txn(1'b0);
      o = obs(1'b0);
      total++;
      if ({out_valid_w, in_ready_w, busy_w} !== 3'b010 || o !== e) begin
         bad++;
         $display("FAIL bp_release got=%b%b%b %h want=010 %h", out_valid_w, in_ready_w, busy_w, o.s, e.s);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] av[3];
      logic [31:0] bv[3];
      int          acc[$];
      int          got;
      int          cyc;
      int          idx;
      bit          prev_rdy;
      exp_t        e;
      exp_t        o;
      av = '{32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
      bv = '{32'h2, 32'h1, 32'h1};
      got = 0; cyc = 0; idx = 0;
      sb.push_back(model(1'b0, av[0], bv[0], 1'b0));
      drive(1'b0, av[0], bv[0], 1'b0, 1'b1);
      out_ready_w = 1'b1;
      prev_rdy = in_ready_w;
      while (got < 3 && cyc < 100) begin
         tick;
         cyc++;
         if (prev_rdy && in_valid_w) begin
            acc.push_back(cyc);
            idx++;
            if (idx < 3) begin
               sb.push_back(model(1'b0, av[idx], bv[idx], 1'b0));
               drive(1'b0, av[idx], bv[idx], 1'b0, 1'b1);
            end else begin
               drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            end
         end
         if (out_valid_w && sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(1'b0);
            total++;
            if (o !== e) begin
               bad++;
               $display("FAIL b2b_result%0d got=%h/%b/%b want=%h/%b/%b", got, o.s, o.co, o.ov, e.s, e.co, e.ov);
            end
            got++;
         end
         prev_rdy = in_ready_w;
      end
      total++;
      if (got != 3 || acc.size() != 3) begin
         bad++;
         $display("FAIL b2b_count got=%0d/%0d want=3/3", got, acc.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            total++;
            if (acc[i] - acc[i-1] != 10) begin
               bad++;
               $display("FAIL b2b_spacing%0d got=%0d want=10", i, acc[i] - acc[i-1]);
            end
         end
      end
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      tick;
      out_ready_w = 1'b0;
   endtask

   task automatic test_reset_mid_run;
      int seen_valid;
      start_txn(1'b0, 32'hFFFF_0000, 32'h0001_FFFF, 1'b0);
      repeat (3) tick;
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      total++;
      if ({sum_w, co_w, ov_w, out_valid_w, busy_w, in_ready_w} !== {32'd0, 5'b00001}) begin
         bad++;
         $display("FAIL midrun_reset got=%h/%b/%b v%b b%b r%b want=0/0/0 v0 b0 r1",
                  sum_w, co_w, ov_w, out_valid_w, busy_w, in_ready_w);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 0;
      for (int i = 0; i < 12; i++) begin
         tick;
         if (out_valid_w) seen_valid++;
      end
      total++;
      if (seen_valid != 0) begin
         bad++;
         $display("FAIL midrun_no_valid got=%0d want=0", seen_valid);
      end
      test_basic(1'b0, 32'h0000_00FF, 32'h0000_0F01, 1'b0, 8, 1'b0, "after_reset");
   endtask

   initial begin
      test_reset;
      test_w4;
      test_sub32;
      test_backpressure;
      test_back_to_back;
      test_reset_mid_run;
      test_corruption;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
